// File: rtl/divider_pkg.sv
// divider_pkg: shared state encoding and default widths for the iterative divider.
package divider_pkg;
    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam logic [DW_DEF-1:0] DBZ_QUOTIENT = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/divider16bit8_if.sv
// divider16bit8_if: start/busy/done request bus carrying operands and results.
interface divider16bit8_if import divider_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] i_pr,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW-1:0] o_pr,
    output logic          o_qbit
);
    // One extra bit so the shifted partial remainder can never overflow.
    logic [VW:0] w_pr;
    logic [VW:0] w_diff;
    assign w_pr   = {i_pr, i_bit};
    assign w_diff = w_pr - {1'b0, i_divisor};
    assign o_qbit = w_pr >= {1'b0, i_divisor};
    assign o_pr   = o_qbit ? w_diff[VW-1:0] : w_pr[VW-1:0];
endmodule

// File: rtl/divider16bit8.sv
// divider16bit8: iterative unsigned restoring divider, one quotient bit per clock.
module divider16bit8 import divider_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input logic            clk,
    input logic            rst,
    divider16bit8_if.slave bus
);
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    state_t        r_state;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_pr;
    logic [VW-1:0] r_divisor;
    logic [VW-1:0] r_remainder;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic [VW-1:0] w_pr_nxt;
    logic          w_qbit;
    // Dividend bits leave at the top of r_shift while quotient bits enter at the bottom.
    div_step #(.VW(VW)) u_step (
        .i_pr(r_pr),
        .i_bit(r_shift[DW-1]),
        .i_divisor(r_divisor),
        .o_pr(w_pr_nxt),
        .o_qbit(w_qbit)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_quotient  <= '0;
            r_pr        <= '0;
            r_divisor   <= '0;
            r_remainder <= '0;
            r_cnt       <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    if (bus.divisor != '0) begin
                        r_shift   <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_pr      <= '0;
                        r_cnt     <= '0;
                        r_dbz     <= 1'b0;
                        r_state   <= RUN;
                    end else begin
                        r_quotient  <= DBZ_QUOTIENT;
                        r_remainder <= bus.dividend[VW-1:0];
                        r_dbz       <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                RUN: begin
                    r_pr    <= w_pr_nxt;
                    r_shift <= {r_shift[DW-2:0], w_qbit};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_quotient  <= {r_shift[DW-2:0], w_qbit};
                        r_remainder <= w_pr_nxt;
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.busy        = r_state == RUN;
    assign bus.done        = r_state == DONE;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider16bit8.sv
// tb_divider16bit8: randomized scoreboard bench for the iterative divider.
module tb_divider16bit8;
    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;
    exp_t exp_q[$];
    divider16bit8_if #(.DW(16), .VW(8)) bus ();
    divider16bit8 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask
    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t e;
        if (dv == 0) begin
            e.q = 16'hFFFF;
            e.r = dd[7:0];
            e.z = 1'b1;
        end else begin
            e.q = dd / {8'd0, dv};
            e.r = 8'(dd % {8'd0, dv});
            e.z = 1'b0;
        end
        return e;
    endfunction
    always @(negedge clk) begin
        if (rst && bus.done) begin
            exp_t e;
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got a done pulse expected none at cycle %0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
            end
        end
    end
    task automatic do_op(input logic [15:0] dd, input logic [7:0] dv);
        int lat;
        int nb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = dd;
        bus.divisor = dv;
        exp_q.push_back(model(dd, dv));
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 8'($urandom);
        lat = 1;
        nb = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), (dv != 0) ? 32'd17 : 32'd1);
        chk("busy_cycles", 32'(nb), (dv != 0) ? 32'd16 : 32'd0);
        @(negedge clk);
    endtask
    initial begin
        int base;
        int k;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_quotient", 32'(bus.quotient), 0);
        chk("reset_remainder", 32'(bus.remainder), 0);
        chk("reset_dbz", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(16'd1000, 8'd7);
        do_op(16'hFFFF, 8'hFF);
        do_op(16'hFFFF, 8'd1);
        do_op(16'd5, 8'd10);
        do_op(16'h1234, 8'd0);
        do_op(16'd77, 8'd5);
        // Stray starts while running and during DONE must be ignored.
        base = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd300;
        bus.divisor = 8'd9;
        exp_q.push_back(model(16'd300, 8'd9));
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 40) begin
            bus.start = (k == 3 || k == 10);
            bus.dividend = 16'($urandom);
            bus.divisor = 8'($urandom_range(1, 255));
            @(negedge clk);
            k++;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        chk("single_done", 32'(n_done - base), 1);
        chk("idle_after_ignored", 32'(bus.busy), 0);
        // Reset partway through an operation aborts it with no done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd500;
        bus.divisor = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        base = n_done;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_quotient", 32'(bus.quotient), 0);
        chk("abort_remainder", 32'(bus.remainder), 0);
        chk("abort_dbz", 32'(bus.div_by_zero), 0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        chk("abort_no_done", 32'(n_done - base), 0);
        @(negedge clk);
        rst = 1'b1;
        do_op(16'd500, 8'd3);
        // Start held high: the second request issues on the first IDLE edge.
        base = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd40000;
        bus.divisor = 8'd200;
        exp_q.push_back(model(16'd40000, 8'd200));
        exp_q.push_back(model(16'd255, 8'd16));
        @(negedge clk);
        bus.dividend = 16'd255;
        bus.divisor = 8'd16;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        @(posedge clk);
        chk("b2b_done_count", 32'(n_done - base), 2);
        chk("b2b_interval", 32'(last_done_cyc - prev_done_cyc), 18);
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] dv;
            dv = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
            do_op(16'($urandom), dv);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
